// File: rtl/run_controller.sv
// run_controller: go handshake -> processor start pulse -> run until halt
// (optionally bounded by a timeout) -> byte dump of a data-memory window -> done.
// Optional feature macro: RUN_CONTROLLER_TIMEOUT_EN (enables the RUN-cycle limit).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | go_ready high, waiting for a run request
// START | cpu_start held high for START_CYCLES cycles
// RUN   | processor running, cycle_count counts non-halt cycles
// RD    | one-cycle memory read strobe at base+index
// OUT   | byte presented on the output stream until out_ready
// DONE  | one-cycle done pulse, then back to IDLE
module run_controller #(
  parameter int unsigned START_CYCLES   = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go_valid,
  output logic        go_ready,
  input  logic [7:0]  dump_base,
  input  logic [7:0]  dump_len,
  output logic        cpu_start,
  input  logic        cpu_halt,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] cycle_count,
  output logic        timeout,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, START, RUN, RD, OUT, DONE} state_t;

  localparam logic [7:0] START_LOAD = 8'(START_CYCLES - 1);

  state_t     state;
  logic [7:0] base_q;
  logic [7:0] len_q;
  logic [7:0] index_q;
  logic [7:0] start_cnt;
  logic       out_first;
  logic [7:0] out_data_q;
  logic       timeout_hit;

`ifdef RUN_CONTROLLER_TIMEOUT_EN
  assign timeout_hit = (cycle_count == TIMEOUT_CYCLES);
`else
  // Timeout disabled: the hit is constant 0; the limit stays in the expression
  // so both builds share the same parameter interface.
  assign timeout_hit = 1'b0 & (cycle_count == TIMEOUT_CYCLES);
`endif

  // Memory data arrives in the first OUT cycle; present it directly then and
  // from the capture register for the rest of the stall so it stays stable.
  assign out_data = out_first ? mem_data : out_data_q;

  // Sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      go_ready    <= 1'b1;
      cpu_start   <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= 8'h00;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_first   <= 1'b0;
      out_data_q  <= 8'h00;
      cycle_count <= 16'h0000;
      timeout     <= 1'b0;
      done        <= 1'b0;
      base_q      <= 8'h00;
      len_q       <= 8'h00;
      index_q     <= 8'h00;
      start_cnt   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (go_valid) begin
            base_q      <= dump_base;
            len_q       <= dump_len;
            cycle_count <= 16'h0000;
            timeout     <= 1'b0;
            go_ready    <= 1'b0;
            cpu_start   <= 1'b1;
            start_cnt   <= START_LOAD;
            state       <= START;
          end
        end
        START: begin
          if (start_cnt == 8'h00) begin
            cpu_start <= 1'b0;
            state     <= RUN;
          end else begin
            start_cnt <= start_cnt - 8'd1;
          end
        end
        RUN: begin
          if (cpu_halt || timeout_hit) begin
            // Halt takes priority over a simultaneous timeout.
            timeout <= ~cpu_halt;
            if (len_q != 8'h00) begin
              index_q  <= 8'h00;
              mem_addr <= base_q;
              mem_rd   <= 1'b1;
              state    <= RD;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
          end
        end
        RD: begin
          mem_rd    <= 1'b0;
          out_valid <= 1'b1;
          out_first <= 1'b1;
          out_last  <= (index_q == len_q - 8'd1);
          state     <= OUT;
        end
        OUT: begin
          out_first <= 1'b0;
          if (out_first) out_data_q <= mem_data;
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index_q  <= index_q + 8'd1;
              mem_addr <= base_q + index_q + 8'd1;
              mem_rd   <= 1'b1;
              state    <= RD;
            end
          end
        end
        DONE: begin
          done     <= 1'b0;
          go_ready <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 Parameter START_CYCLES, default 2: number of cycles cpu_start is held high per run (legal range 1-255).
REQ-002 Parameter TIMEOUT_CYCLES, default 16'hFFFF: RUN-cycle limit before the run is abandoned.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 go_valid  in  1  host requests a run.
REQ-006 go_ready  out  1  controller can accept a run request.
REQ-007 dump_base  in  8  first data-memory address to dump; latched at the go handshake.
REQ-008 dump_len  in  8  number of bytes to dump (0 = no dump); latched at the go handshake.
REQ-009 cpu_start  out  1  drives processor start (PC reset).
REQ-010 cpu_halt  in  1  processor halt flag.
REQ-011 mem_addr  out  8  data-memory read address.
REQ-012 mem_rd  out  1  data-memory read strobe.
REQ-013 mem_data  in  8  data-memory read data, valid the cycle after mem_rd.
REQ-014 out_valid / out_ready / out_data[7:0] / out_last  out/in/out/out  dump byte stream.
REQ-015 cycle_count  out  16  RUN cycles of the last run.
REQ-016 timeout  out  1  last run hit TIMEOUT_CYCLES.
REQ-017 done  out  1  one-cycle pulse at the end of each run.

Function
REQ-018 States SHALL be: IDLE, START, RUN, RD, OUT, DONE.
REQ-019 IDLE: go_ready=1; on go_valid&go_ready, latch base/len, clear cycle_count and timeout, go to START.
REQ-020 START: cpu_start=1 for exactly START_CYCLES cycles, then go to RUN; cpu_halt is ignored in START.
REQ-021 RUN: cpu_start=0; each cycle with cpu_halt=0, cycle_count increments, saturating at 16'hFFFF.
REQ-022 RUN: cpu_halt=1 ends RUN, with no increment that cycle; go to RD if len!=0, else go to DONE.
REQ-023 RUN: cycle_count reaching TIMEOUT_CYCLES sets timeout=1 and ends RUN with the same transition as REQ-022.
REQ-024 Halt and the timeout condition in the same cycle: halt wins, timeout stays 0.
REQ-025 RD: mem_rd=1, mem_addr=base+index (mod 256, wraps FF->00); always go to OUT next cycle.
REQ-026 OUT: capture mem_data into out_data on entry; out_valid=1 with out_data stable until out_ready.
REQ-027 OUT: out_last=1 on index len-1; after the handshake, go to RD with index+1, or to DONE after the last byte.
REQ-028 out_valid SHALL NOT deassert without a handshake; out_ready has no effect outside OUT.
REQ-029 DONE: done=1 for one cycle, then return to IDLE; cycle_count and timeout hold until the next go handshake.
REQ-030 go_valid outside IDLE SHALL be ignored (go_ready=0).
REQ-031 Total latency from go handshake to done: START_CYCLES + RUN cycles + 1 + sum over bytes of (2 + stall cycles).

Reset
REQ-032 reset asserted in any state SHALL force IDLE immediately, with no completion of any in-flight operation.
REQ-033 Reset values: go_ready=1, cpu_start=0, mem_rd=0, mem_addr=0, out_valid=0, out_last=0, out_data=0, cycle_count=0, timeout=0, done=0.
REQ-034 Reset mid-dump SHALL drop out_valid without a handshake; the host discards the partial dump.

Configuration
REQ-035 Macro RUN_CONTROLLER_TIMEOUT_EN: when defined, REQ-023 applies.
REQ-036 When RUN_CONTROLLER_TIMEOUT_EN is undefined, RUN waits indefinitely for cpu_halt, timeout is tied 0, and TIMEOUT_CYCLES is unused.

Verification
REQ-037 go with len=0; halt rises after 10 RUN cycles -> cpu_start high 2 cycles, cycle_count=10, done pulse, no out_valid.
REQ-038 base=8'hFE, len=4, memory FE..01 = 11,22,33,44, out_ready=1 -> mem_addr FE,FF,00,01; bytes 11,22,33,44; out_last only on 44.
REQ-039 len=2 with out_ready low for 3 cycles on byte 0 -> out_data held stable, out_valid held, both bytes delivered in order.
REQ-040 TIMEOUT_EN defined, TIMEOUT_CYCLES=20, halt never rises -> timeout=1, cycle_count=20, dump then done.
REQ-041 TIMEOUT_EN defined, halt rises on the same cycle the count reaches the limit -> timeout=0.
REQ-042 reset pulsed during OUT and during START -> all outputs at reset values next cycle, go_ready=1.
